channel_arbiter: RTL and testbench

CHANNEL_ARBITER -- requirements
Module: channel_arbiter

---
 rtl/chan_pkg.sv | 23 ++
 rtl/rr_pick.sv | 41 ++++
 rtl/channel_arbiter.sv | 139 +++++++++++++
 tb/tb_channel_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/chan_pkg.sv
// Shared types for the channel arbiter: channel index, channel-count ceiling,
// arbitration FSM states and the round-robin pointer advance.
package chan_pkg;

    localparam int MAX_CH = 8;
    localparam int IDX_W  = 3;

    typedef logic [IDX_W-1:0] ch_idx_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Pointer moves one past the released channel, wrapping at the configured count.
    function automatic ch_idx_t next_idx(input ch_idx_t idx, input int num_ch);
        if (int'(idx) + 1 >= num_ch)
            return ch_idx_t'(0);
        else
            return ch_idx_t'(idx + 1'b1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first requesting index at or after ptr,
// searching upward with wrap. Returns one-hot grant, its index and a found flag.
module rr_pick
    import chan_pkg::*;
#(
    parameter int NUM_CH = 8
) (
    input  logic [NUM_CH-1:0] req,
    input  ch_idx_t           ptr,
    output logic [NUM_CH-1:0] grant,
    output ch_idx_t           idx,
    output logic              found
);

    typedef logic [IDX_W:0] pos_t;

    logic [MAX_CH-1:0] req_ext;
    logic [MAX_CH-1:0] grant_ext;

    assign req_ext = MAX_CH'(req);
    assign grant   = grant_ext[NUM_CH-1:0];

    always_comb begin
        // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
        grant_ext = '0;
        idx       = '0;
        found     = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            pos_t pos;
            pos = pos_t'(ptr) + pos_t'(k);
            if (pos >= pos_t'(NUM_CH))
                pos = pos - pos_t'(NUM_CH);
            if (!found && req_ext[pos[IDX_W-1:0]]) begin
                found                       = 1'b1;
                idx                         = pos[IDX_W-1:0];
                grant_ext[pos[IDX_W-1:0]]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/channel_arbiter.sv
// Round-robin merge of NUM_CH AXI-stream channels into one registered stream tagged
// with the source channel. Packet locking is built in when CHANNEL_ARBITER_PKT_LOCK_EN is defined.
module channel_arbiter
    import chan_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 24
) (
    input  logic                     s_axis_aclk,
    input  logic                     s_axis_areset,
    input  logic [NUM_CH-1:0]        ch_enable,
    input  logic [NUM_CH*DATA_W-1:0] s_axis_tdata,
    input  logic [NUM_CH-1:0]        s_axis_tvalid,
    input  logic [NUM_CH-1:0]        s_axis_tlast,
    output logic [NUM_CH-1:0]        s_axis_tready,
    output logic [DATA_W-1:0]        m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic [2:0]               m_axis_tuser
);

    logic [DATA_W-1:0] ch_data [MAX_CH];
    logic [MAX_CH-1:0] last_ext;

    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] pick_grant;
    ch_idx_t           pick_idx;
    logic              pick_found;

    ch_idx_t           rr_ptr;
    ch_idx_t           grant_idx;
    logic [NUM_CH-1:0] grant_vec;
    logic              grant_vld;
    logic              out_free;
    logic              accept;
    logic              beat_last;
    logic              release_grant;

    // Unused slots above NUM_CH read as zero so any 3-bit index stays in range.
    always_comb begin
        for (int i = 0; i < MAX_CH; i++)
            ch_data[i] = '0;
        for (int i = 0; i < NUM_CH; i++)
            ch_data[i] = s_axis_tdata[i*DATA_W +: DATA_W];
    end

    assign last_ext = MAX_CH'(s_axis_tlast);
    assign req      = s_axis_tvalid & ch_enable;
    assign out_free = !m_axis_tvalid || m_axis_tready;

    rr_pick #(
        .NUM_CH (NUM_CH)
    ) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .found (pick_found)
    );

`ifdef CHANNEL_ARBITER_PKT_LOCK_EN
    arb_state_t        state;
    arb_state_t        state_nxt;
    ch_idx_t           lock_ch;
    logic [MAX_CH-1:0] valid_ext;

    assign valid_ext = MAX_CH'(s_axis_tvalid);

    always_ff @(posedge s_axis_aclk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (s_axis_areset) begin
            state   <= IDLE;
            lock_ch <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && accept && !beat_last)
                lock_ch <= pick_idx;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && !beat_last) state_nxt = LOCKED;
            LOCKED:  if (accept && beat_last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A locked channel ignores ch_enable and the pointer; only its own tvalid matters.
    always_comb begin
        grant_idx = pick_idx;
        grant_vec = pick_grant;
        grant_vld = pick_found;
        if (state == LOCKED) begin
            grant_idx = lock_ch;
            grant_vec = NUM_CH'(MAX_CH'(1) << lock_ch);
            grant_vld = valid_ext[lock_ch];
        end
    end

    assign release_grant = accept && beat_last;
`else
    assign grant_idx     = pick_idx;
    assign grant_vec     = pick_grant;
    assign grant_vld     = pick_found;
    assign release_grant = accept;
`endif

    assign accept        = grant_vld && out_free && !s_axis_areset;
    assign beat_last     = last_ext[grant_idx];
    assign s_axis_tready = accept ? grant_vec : '0;

    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset)
            rr_ptr <= '0;
        else if (release_grant)
            rr_ptr <= next_idx(grant_idx, NUM_CH);
    end

    // Output register: load on accept, drain on ready, otherwise hold.
    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (accept) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= ch_data[grant_idx];
            m_axis_tuser  <= grant_idx;
            m_axis_tlast  <= beat_last;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_channel_arbiter.sv
// Self-checking bench for channel_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the arbitration rules.
module tb_channel_arbiter;

    localparam int NUM_CH = 8;
    localparam int DATA_W = 24;
`ifdef CHANNEL_ARBITER_PKT_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_CH-1:0]        en;
    logic [NUM_CH-1:0]        tvalid;
    logic [NUM_CH-1:0]        tlast;
    logic [NUM_CH-1:0]        s_tready;
    logic [DATA_W-1:0]        din [NUM_CH];
    logic [NUM_CH*DATA_W-1:0] s_tdata;
    logic [DATA_W-1:0]        m_tdata;
    logic                     m_tvalid;
    logic                     mready;
    logic                     m_tlast;
    logic [2:0]               m_tuser;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int                m_ptr = 0;
    bit                m_locked = 1'b0;
    int                m_lock_ch = 0;
    logic              mv = 1'b0;
    logic [DATA_W-1:0] md = '0;
    logic [2:0]        mu = '0;
    logic              ml = 1'b0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++)
            s_tdata[i*DATA_W +: DATA_W] = din[i];
    end

    channel_arbiter #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W)
    ) dut (
        .s_axis_aclk   (clk),
        .s_axis_areset (rst),
        .ch_enable     (en),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (tvalid),
        .s_axis_tlast  (tlast),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (mready),
        .m_axis_tlast  (m_tlast),
        .m_axis_tuser  (m_tuser)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int mdl_pick(input logic [NUM_CH-1:0] v, input logic [NUM_CH-1:0] e, input int p);
        for (int k = 0; k < NUM_CH; k++) begin
            int c;
            c = (p + k) % NUM_CH;
            if (v[c] && e[c])
                return c;
        end
        return -1;
    endfunction

    // One clock: check ready before the edge, advance the model, check outputs after it.
    task automatic step();
        int                g;
        bit                free;
        logic [NUM_CH-1:0] er;
        @(negedge clk);
        free = !mv || mready;
        if (m_locked)
            g = tvalid[m_lock_ch] ? m_lock_ch : -1;
        else
            g = mdl_pick(tvalid, en, m_ptr);
        er = '0;
        if (g >= 0 && free && !rst)
            er[g] = 1'b1;
        check("s_axis_tready", 64'(s_tready), 64'(er));
        @(posedge clk);
        if (rst) begin
            mv = 1'b0; md = '0; mu = '0; ml = 1'b0;
            m_ptr = 0; m_locked = 1'b0; m_lock_ch = 0;
        end else if (er != '0) begin
            mv = 1'b1; md = din[g]; mu = 3'(g); ml = tlast[g];
            if (!LOCK_EN || tlast[g]) begin
                m_locked = 1'b0;
                m_ptr = (g + 1) % NUM_CH;
            end else if (!m_locked) begin
                m_locked = 1'b1;
                m_lock_ch = g;
            end
        end else if (mready) begin
            mv = 1'b0;
        end
        #1;
        check("m_axis_tvalid", 64'(m_tvalid), 64'(mv));
        check("m_axis_tdata", 64'(m_tdata), 64'(md));
        check("m_axis_tuser", 64'(m_tuser), 64'(mu));
        check("m_axis_tlast", 64'(m_tlast), 64'(ml));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tvalid = '0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int seq_a [6];
        int seq_b [8];
        seq_a = '{0, 2, 5, 0, 2, 5};
        seq_b = '{0, 1, 3, 4, 5, 6, 7, 0};

        rst = 1'b1; en = '1; tvalid = '0; tlast = '0; mready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) din[i] = DATA_W'(32'h10 * (i + 1));
        step();
        tvalid = '1;
        step();
        check("rst_tvalid", 64'(m_tvalid), 64'(0));
        check("rst_tdata", 64'(m_tdata), 64'(0));
        check("rst_tuser", 64'(m_tuser), 64'(0));
        check("rst_tready", 64'(s_tready), 64'(0));

        // Per-beat round robin across ch0, ch2, ch5
        do_reset();
        tvalid = 8'b0010_0101; tlast = '1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("rr_seq_valid", 64'(m_tvalid), 64'(1));
            check("rr_seq_tuser", 64'(m_tuser), 64'(seq_a[i]));
        end

        // Backpressure with ch1 holding the full-scale positive sample
        do_reset();
        tvalid = 8'b0000_0010; tlast = '1; din[1] = 24'h7FFFFF;
        step();
        din[1] = 24'h000011;
        mready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("bp_hold_data", 64'(m_tdata), 64'h7FFFFF);
            check("bp_hold_user", 64'(m_tuser), 64'(1));
            check("bp_ready_low", 64'(s_tready), 64'(0));
        end
        mready = 1'b1;
        step();
        check("bp_release_data", 64'(m_tdata), 64'h000011);
        tvalid = '0;
        step();
        check("bp_drain_valid", 64'(m_tvalid), 64'(0));

        // Masking ch2 out of an all-valid set
        do_reset();
        en = 8'b1111_1011; tvalid = '1; tlast = '1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("mask_tuser", 64'(m_tuser), 64'(seq_b[i]));
        end
        en = '1;

`ifdef CHANNEL_ARBITER_PKT_LOCK_EN
        // ch3 packet of 4 beats while ch4 waits; dropping ch3's enable mid-packet must not revoke it
        do_reset();
        tvalid = 8'b0001_1000; tlast = '0;
        for (int i = 0; i < 4; i++) begin
            tlast[3] = (i == 3);
            din[3] = DATA_W'(32'h300 + i);
            en[3] = (i != 2);
            step();
            check("lock_tuser", 64'(m_tuser), 64'(3));
            check("lock_tlast", 64'(m_tlast), 64'(i == 3));
        end
        tlast = '1;
        step();
        check("lock_next_tuser", 64'(m_tuser), 64'(4));
        en = '1;
`endif

        // Reset during beat 2 of a ch6 packet
        do_reset();
        tvalid = 8'b0100_0000; tlast = '0;
        step();
        rst = 1'b1;
        step();
        check("midrst_tvalid", 64'(m_tvalid), 64'(0));
        rst = 1'b0;
        tvalid = 8'b0100_0001; tlast = '1;
        step();
        check("midrst_first_tuser", 64'(m_tuser), 64'(0));
        check("midrst_first_valid", 64'(m_tvalid), 64'(1));

        // Randomized traffic, enables, backpressure and occasional resets
        do_reset();
        for (int n = 0; n < 400; n++) begin
            tvalid = NUM_CH'($urandom);
            en     = NUM_CH'($urandom | $urandom);
            tlast  = NUM_CH'($urandom);
            for (int i = 0; i < NUM_CH; i++) din[i] = DATA_W'($urandom);
            mready = ($urandom_range(0, 3) != 0);
            rst    = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
